// File: rtl/bcd_stopwatch_n.sv
// BCD stopwatch / countdown timer with a tick prescaler, lap capture,
// preset load and a terminal-count flag. Digits are packed MS digit first.
module bcd_stopwatch_n #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  lap,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  dir,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   lap_val,
  output logic                  lap_valid,
  output logic                  running,
  output logic                  done
);

  localparam int W = 4 * DIGITS;
  localparam logic [15:0] PrescMax = 16'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   lapVal_q, lapVal_d;
  logic           lapValid_q, lapValid_d;
  logic [15:0]    presc_q, presc_d;
  logic           dir_q, dir_d;
  logic [W-1:0]   idleCount;
  logic [W-1:0]   stepped;

  function automatic logic [W-1:0] bcdInc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcdDec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcdClamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Terminal means all nines when counting up, all zeros when counting down.
  function automatic logic isTerminal(input logic [W-1:0] v, input logic down);
    logic t;
    t = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] != (down ? 4'd0 : 4'd9)) t = 1'b0;
    end
    return t;
  endfunction

  // Next-state decode: clear overrides everything, lap works in any active state.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    lapVal_d   = lapVal_q;
    lapValid_d = 1'b0;
    presc_d    = presc_q;
    dir_d      = dir_q;
    idleCount  = load ? bcdClamp(load_val) : count_q;
    stepped    = dir_q ? bcdDec(count_q) : bcdInc(count_q);

    if (clear) begin
      state_d = StIdle;
      count_d = '0;
      presc_d = '0;
    end else begin
      if (lap && (state_q == StRun || state_q == StPause || state_q == StDone)) begin
        lapVal_d   = count_q;
        lapValid_d = 1'b1;
      end
      case (state_q)
        StIdle: begin
          presc_d = '0;
          count_d = idleCount;
          if (start) begin
            dir_d   = dir;
            state_d = isTerminal(idleCount, dir) ? StDone : StRun;
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StPause;
          end else if (presc_q == PrescMax) begin
            presc_d = '0;
            count_d = stepped;
            if (isTerminal(stepped, dir_q)) state_d = StDone;
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        StPause: begin
          if (start) state_d = StRun;
        end
        StDone: begin
          presc_d = '0;
        end
        default: begin
          state_d = StIdle;
          presc_d = '0;
        end
      endcase
    end
  end

  // State register; every output comes from here or from the state code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      lapVal_q   <= '0;
      lapValid_q <= 1'b0;
      presc_q    <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      lapVal_q   <= lapVal_d;
      lapValid_q <= lapValid_d;
      presc_q    <= presc_d;
      dir_q      <= dir_d;
    end
  end

  assign count     = count_q;
  assign lap_val   = lapVal_q;
  assign lap_valid = lapValid_q;
  assign running   = (state_q == StRun);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_bcd_stopwatch_n.sv
// Scoreboard bench for bcd_stopwatch_n: one instance with TICK_DIV=1 and one
// with TICK_DIV=3 share the stimulus; sel picks which one is being checked.
module tb_bcd_stopwatch_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0, load = 1'b0, dir = 1'b0;
  logic [15:0] loadVal = '0;
  logic        sel = 1'b0;

  logic [15:0] countA, lapA, countB, lapB;
  logic        lapValidA, runA, doneA, lapValidB, runB, doneB;
  logic [15:0] countM, lapM;
  logic        lapValidM, runM, doneM;

  typedef struct {
    string       name;
    logic [15:0] count;
    logic        run;
    logic        done;
    bit          chkLap;
    logic [15:0] lapVal;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] lapQ[$];
  int          checkCount = 0;
  int          passCount  = 0;
  event        sampleEv;

  bcd_stopwatch_n #(.DIGITS(4), .TICK_DIV(1)) dutA (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .load(load), .load_val(loadVal), .dir(dir), .count(countA), .lap_val(lapA),
    .lap_valid(lapValidA), .running(runA), .done(doneA)
  );

  bcd_stopwatch_n #(.DIGITS(4), .TICK_DIV(3)) dutB (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .load(load), .load_val(loadVal), .dir(dir), .count(countB), .lap_val(lapB),
    .lap_valid(lapValidB), .running(runB), .done(doneB)
  );

  always #5 clk = ~clk;

  // Route the instance under test to the monitor.
  always_comb begin
    countM    = sel ? countB    : countA;
    lapM      = sel ? lapB      : lapA;
    lapValidM = sel ? lapValidB : lapValidA;
    runM      = sel ? runB      : runA;
    doneM     = sel ? doneB     : doneA;
  end

  task automatic drainExpected();
    exp_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkCount++;
      if (countM === e.count && runM === e.run && doneM === e.done &&
          (!e.chkLap || lapM === e.lapVal)) begin
        passCount++;
      end else begin
        $display("[TB] FAIL %s: got count=%h running=%b done=%b lap_val=%h, want count=%h running=%b done=%b lap_val=%h",
                 e.name, countM, runM, doneM, lapM, e.count, e.run, e.done,
                 e.chkLap ? e.lapVal : lapM);
      end
    end
  endtask

  // Monitor: compares queued expectations and every lap_valid pulse.
  always @(negedge clk) begin
    drainExpected();
    if (lapValidM === 1'b1) begin
      checkCount++;
      if (lapQ.size() == 0) begin
        $display("[TB] FAIL lap_unexpected: got lap_valid=1 lap_val=%h, want no pulse", lapM);
      end else begin
        logic [15:0] want;
        want = lapQ.pop_front();
        if (lapM === want) passCount++;
        else $display("[TB] FAIL lap_val: got %h, want %h", lapM, want);
      end
    end
  end

  // Monitor wake-up for checks taken between clock edges (async reset).
  always @(sampleEv) drainExpected();

  task automatic checkOutput(input string name, input logic [15:0] c, input logic r, input logic d);
    exp_t e;
    e.name = name; e.count = c; e.run = r; e.done = d; e.chkLap = 1'b0; e.lapVal = '0;
    expQ.push_back(e);
  endtask

  task automatic checkReset(input string name);
    exp_t e;
    e.name = name; e.count = '0; e.run = 1'b0; e.done = 1'b0; e.chkLap = 1'b1; e.lapVal = '0;
    expQ.push_back(e);
  endtask

  task automatic expectLap(input logic [15:0] v);
    lapQ.push_back(v);
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic cl, input logic lp,
                               input logic ld, input logic [15:0] lv, input logic d);
    start = st; stop = sp; clear = cl; lap = lp; load = ld; loadVal = lv; dir = d;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; load = 1'b0; loadVal = '0; dir = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  // Pull rst low between edges and check the reset values before any edge.
  task automatic resetPulse(input string name, input logic useB);
    @(negedge clk);
    #1;
    sel = useB;
    rst = 1'b0;
    #1;
    checkReset(name);
    ->sampleEv;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [15:0] upTbl[10];

  initial begin
    upTbl = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005,
              16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h0010};

    // Power-on reset, TICK_DIV=1 instance under test.
    #1 rst = 1'b0;
    #1 checkReset("resetA");
    ->sampleEv;
    @(posedge clk);
    #1 rst = 1'b1;

    // Count up one step per edge, lap mid-run, reach all nines.
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 0); checkOutput("startUp", 16'h0000, 1, 0);
    for (int i = 0; i < 10; i++) begin
      idle(1); checkOutput("countUp", upTbl[i], 1, 0);
    end
    idle(32); checkOutput("at0042", 16'h0042, 1, 0);
    expectLap(16'h0042);
    applyStimulus(0, 0, 0, 1, 0, 16'h0000, 0); checkOutput("lapRun", 16'h0043, 1, 0);
    idle(9955); checkOutput("at9998", 16'h9998, 1, 0);
    idle(1); checkOutput("reach9999", 16'h9999, 0, 1);
    applyStimulus(1, 1, 0, 0, 1, 16'h1234, 0); checkOutput("doneHolds", 16'h9999, 0, 1);
    expectLap(16'h9999);
    applyStimulus(0, 0, 0, 1, 0, 16'h0000, 0); checkOutput("lapDone", 16'h9999, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 0); checkOutput("clearDone", 16'h0000, 0, 0);

    // Preset load with digit clamping, then count down from 0100.
    applyStimulus(0, 0, 0, 0, 1, 16'h00A5, 0); checkOutput("clampA5", 16'h0095, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'hFA3C, 0); checkOutput("clampFA3C", 16'h9939, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 16'h0100, 1); checkOutput("loadStartDown", 16'h0100, 1, 0);
    idle(1); checkOutput("down0099", 16'h0099, 1, 0);
    idle(1); checkOutput("down0098", 16'h0098, 1, 0);
    idle(97); checkOutput("down0001", 16'h0001, 1, 0);
    idle(1); checkOutput("down0000", 16'h0000, 0, 1);

    // Start down at zero is terminal at once; clear beats everything in RUN.
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 0); checkOutput("clear2", 16'h0000, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 1); checkOutput("startAtZeroDown", 16'h0000, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 0); checkOutput("clear3", 16'h0000, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 0); checkOutput("restart", 16'h0000, 1, 0);
    idle(2); checkOutput("run0002", 16'h0002, 1, 0);
    applyStimulus(1, 1, 1, 1, 0, 16'h0000, 0); checkOutput("clearAll", 16'h0000, 0, 0);
    idle(2); checkOutput("idleAfterClear", 16'h0000, 0, 0);

    // Switch to the TICK_DIV=3 instance.
    resetPulse("resetB", 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 0); checkOutput("startB", 16'h0000, 1, 0);
    idle(2); checkOutput("preTick", 16'h0000, 1, 0);
    idle(1); checkOutput("tick1", 16'h0001, 1, 0);
    idle(3); checkOutput("tick2", 16'h0002, 1, 0);
    idle(1); checkOutput("wait7", 16'h0002, 1, 0);
    idle(1); checkOutput("prescAt2", 16'h0002, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 16'h0000, 0); checkOutput("stopOnTick", 16'h0002, 0, 0);
    idle(2); checkOutput("pauseHold", 16'h0002, 0, 0);
    expectLap(16'h0002);
    applyStimulus(0, 1, 0, 1, 1, 16'h5555, 0); checkOutput("pauseIgnores", 16'h0002, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 0); checkOutput("resume", 16'h0002, 1, 0);
    idle(1); checkOutput("resumeStep", 16'h0003, 1, 0);
    expectLap(16'h0003);
    applyStimulus(0, 0, 0, 1, 0, 16'h0000, 0); checkOutput("lapHold1", 16'h0003, 1, 0);
    expectLap(16'h0003);
    applyStimulus(0, 0, 0, 1, 0, 16'h0000, 0); checkOutput("lapHold2", 16'h0003, 1, 0);
    expectLap(16'h0003);
    applyStimulus(0, 0, 0, 1, 0, 16'h0000, 0); checkOutput("lapOnTick", 16'h0004, 1, 0);
    idle(1); checkOutput("afterLap", 16'h0004, 1, 0);

    // Asynchronous reset in the middle of a run.
    applyStimulus(0, 0, 1, 0, 0, 16'h0000, 0); checkOutput("clearB", 16'h0000, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 16'h0517, 0); checkOutput("load0517", 16'h0517, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 0); checkOutput("run0517", 16'h0517, 1, 0);
    idle(1); checkOutput("hold0517", 16'h0517, 1, 0);
    resetPulse("rstMidRun", 1'b1);
    idle(3); checkOutput("noCountAfterRst", 16'h0000, 0, 0);

    @(negedge clk);
    #1;
    checkCount++;
    if (lapQ.size() == 0 && expQ.size() == 0) passCount++;
    else $display("[TB] FAIL queues_empty: got %0d lap and %0d output entries pending, want 0 and 0",
                  lapQ.size(), expQ.size());

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
